// File: rtl/mips_pkg.sv
// Shared MIPS core definitions used by the multiply sequencer.
// Holds the sequencer state encoding and the native multiply operand width.
package mips_pkg;

  // Native operand width of MULT/MULTU; the product is twice this wide.
  localparam int MULT_WIDTH = 32;

  // Multiply sequencer states, 3-bit encoded.
  typedef enum logic [2:0] {
    MS_IDLE   = 3'd0,
    MS_PREP_A = 3'd1,
    MS_PREP_B = 3'd2,
    MS_RUN    = 3'd3,
    MS_FIX_LO = 3'd4,
    MS_FIX_HI = 3'd5,
    MS_DONE   = 3'd6
  } ms_state_e;

endpackage : mips_pkg

// File: rtl/mult_sequencer_adder.sv
// Plain WIDTH-bit adder shared by every arithmetic step of the multiply
// sequencer. Carry-out is not produced here; the sequencer derives it.
module mult_sequencer_adder #(
  parameter int WIDTH = 32
) (
  input  logic [WIDTH-1:0] a_i,
  input  logic [WIDTH-1:0] b_i,
  output logic [WIDTH-1:0] sum_o
);

  assign sum_o = a_i + b_i;

endmodule : mult_sequencer_adder

// File: rtl/mult_sequencer.sv
// Multi-cycle shift-add multiplier for MULT/MULTU.
// Takes operand magnitudes, runs WIDTH shift-add iterations through one
// shared adder, then negates the 2*WIDTH product when the signs differ.
// Fixed latency: done pulses in cycle WIDTH+5 after the start edge.
// Optional feature: define MULT_SEQ_ABORT_EN to add an 'abort' input that
// drops an in-flight operation (any busy state except DONE) back to IDLE.
module mult_sequencer
  import mips_pkg::*;
#(
  parameter int WIDTH = MULT_WIDTH
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             start,
  input  logic             signed_op,
  input  logic [WIDTH-1:0] op_a,
  input  logic [WIDTH-1:0] op_b,
`ifdef MULT_SEQ_ABORT_EN
  input  logic             abort,
`endif
  output logic             busy,
  output logic             done,
  output logic [WIDTH-1:0] hi,
  output logic [WIDTH-1:0] lo
);

  localparam int                CNT_W    = $clog2(WIDTH);
  localparam logic [CNT_W-1:0]  CNT_LAST = CNT_W'(WIDTH - 1);
  localparam logic [WIDTH-1:0]  ONE      = {{(WIDTH-1){1'b0}}, 1'b1};

  ms_state_e        state_q, state_d;
  logic [WIDTH-1:0] a_q,   a_d;     // multiplicand, then |a|
  logic [WIDTH-1:0] mpl_q, mpl_d;   // multiplier, then low product half
  logic [WIDTH-1:0] acc_q, acc_d;   // high product half
  logic             sgn_q, sgn_d;   // operation is signed
  logic             neg_q, neg_d;   // final product must be negated
  logic             z_q,   z_d;     // low half was zero: carry into high half
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic [WIDTH-1:0] hi_q,  hi_d;
  logic [WIDTH-1:0] lo_q,  lo_d;

  logic [WIDTH-1:0] add_a, add_b, add_sum;
  logic             carry;
  logic [WIDTH:0]   step;
  logic             abort_req;

  mult_sequencer_adder #(.WIDTH(WIDTH)) u_adder (
    .a_i   (add_a),
    .b_i   (add_b),
    .sum_o (add_sum)
  );

`ifdef MULT_SEQ_ABORT_EN
  assign abort_req = abort && (state_q != MS_IDLE) && (state_q != MS_DONE);
`else
  assign abort_req = 1'b0;
`endif

  // Unsigned carry-out of the accumulate step, from the wrap-around compare.
  assign carry = add_sum < acc_q;

  // One shift-add iteration: add |a| when the multiplier LSB is set, shift right.
  assign step = mpl_q[0] ? {carry, add_sum} : {1'b0, acc_q};

  // Next-state, adder operand muxing and datapath updates.
  always_comb begin
    // NOTE: every signal gets a default first so no path through the case infers a latch.
    state_d = state_q;
    a_d     = a_q;
    mpl_d   = mpl_q;
    acc_d   = acc_q;
    sgn_d   = sgn_q;
    neg_d   = neg_q;
    z_d     = z_q;
    cnt_d   = cnt_q;
    hi_d    = hi_q;
    lo_d    = lo_q;
    add_a   = acc_q;
    add_b   = a_q;

    if (abort_req) begin
      state_d = MS_IDLE;
    end else begin
      unique case (state_q)
        MS_IDLE: begin
          if (start) begin
            a_d     = op_a;
            mpl_d   = op_b;
            sgn_d   = signed_op;
            neg_d   = signed_op & (op_a[WIDTH-1] ^ op_b[WIDTH-1]);
            state_d = MS_PREP_A;
          end
        end
        MS_PREP_A: begin
          add_a = ~a_q;
          add_b = ONE;
          if (sgn_q && a_q[WIDTH-1]) a_d = add_sum;
          state_d = MS_PREP_B;
        end
        MS_PREP_B: begin
          add_a = ~mpl_q;
          add_b = ONE;
          if (sgn_q && mpl_q[WIDTH-1]) mpl_d = add_sum;
          acc_d   = '0;
          cnt_d   = '0;
          state_d = MS_RUN;
        end
        MS_RUN: begin
          acc_d = step[WIDTH:1];
          mpl_d = {step[0], mpl_q[WIDTH-1:1]};
          cnt_d = cnt_q + 1'b1;
          if (cnt_q == CNT_LAST) state_d = MS_FIX_LO;
        end
        MS_FIX_LO: begin
          add_a = ~mpl_q;
          add_b = ONE;
          z_d   = (mpl_q == '0);
          if (neg_q) mpl_d = add_sum;
          state_d = MS_FIX_HI;
        end
        MS_FIX_HI: begin
          // Results land in hi/lo on the edge into DONE so they are valid with done.
          add_a = ~acc_q;
          add_b = {{(WIDTH-1){1'b0}}, z_q};
          acc_d   = neg_q ? add_sum : acc_q;
          hi_d    = acc_d;
          lo_d    = mpl_q;
          state_d = MS_DONE;
        end
        MS_DONE: begin
          state_d = MS_IDLE;
        end
        default: begin
          state_d = MS_IDLE;
        end
      endcase
    end
  end

  // State and datapath registers with synchronous active-low reset.
  always_ff @(posedge clk) begin
    // NOTE: sequential state uses non-blocking assignments so all registers update together.
    if (!rst_n) begin
      state_q <= MS_IDLE;
      a_q     <= '0;
      mpl_q   <= '0;
      acc_q   <= '0;
      sgn_q   <= 1'b0;
      neg_q   <= 1'b0;
      z_q     <= 1'b0;
      cnt_q   <= '0;
      hi_q    <= '0;
      lo_q    <= '0;
    end else begin
      state_q <= state_d;
      a_q     <= a_d;
      mpl_q   <= mpl_d;
      acc_q   <= acc_d;
      sgn_q   <= sgn_d;
      neg_q   <= neg_d;
      z_q     <= z_d;
      cnt_q   <= cnt_d;
      hi_q    <= hi_d;
      lo_q    <= lo_d;
    end
  end

  assign busy = (state_q != MS_IDLE);
  assign done = (state_q == MS_DONE);
  assign hi   = hi_q;
  assign lo   = lo_q;

endmodule : mult_sequencer

// File: tb/tb_mult_sequencer.sv
// Self-checking bench for mult_sequencer: directed corner products, random
// MULT/MULTU operations against a 64-bit arithmetic reference, ignored
// starts while busy, mid-operation reset, and abort when MULT_SEQ_ABORT_EN.
module tb_mult_sequencer;
  import mips_pkg::*;

  localparam int W   = MULT_WIDTH;
  localparam int LAT = W + 5;

  logic         clk = 1'b0;
  logic         rst_n = 1'b0;
  logic         start = 1'b0;
  logic         signed_op = 1'b0;
  logic [W-1:0] op_a = '0;
  logic [W-1:0] op_b = '0;
`ifdef MULT_SEQ_ABORT_EN
  logic         abort = 1'b0;
`endif
  logic         busy, done;
  logic [W-1:0] hi, lo;

  int n_checks = 0;
  int n_errors = 0;
  logic [63:0] last_res = '0;

  mult_sequencer #(.WIDTH(W)) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .start     (start),
    .signed_op (signed_op),
    .op_a      (op_a),
    .op_b      (op_b),
`ifdef MULT_SEQ_ABORT_EN
    .abort     (abort),
`endif
    .busy      (busy),
    .done      (done),
    .hi        (hi),
    .lo        (lo)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  // Reference product from plain 64-bit arithmetic.
  function automatic logic [63:0] ref_mul(input logic [W-1:0] a, input logic [W-1:0] b,
                                          input logic s);
    longint sa, sb;
    logic [63:0] ua, ub;
    if (s) begin
      sa = longint'($signed(a));
      sb = longint'($signed(b));
      return 64'(sa * sb);
    end
    ua = {32'h0, a};
    ub = {32'h0, b};
    return ua * ub;
  endfunction

  // Launch one operation and follow it for a bounded number of cycles.
  task automatic run_op(input logic [W-1:0] a, input logic [W-1:0] b, input logic s,
                        input bit poke, input string tag);
    logic [63:0] exp, got;
    int first_done, n_done;
    bit busy_ok, hold_ok;
    exp = ref_mul(a, b, s);
    got = '0;
    first_done = -1;
    n_done = 0;
    busy_ok = 1'b1;
    hold_ok = 1'b1;
    @(negedge clk);
    start = 1'b1; op_a = a; op_b = b; signed_op = s;
    for (int cyc = 1; cyc <= LAT + 3; cyc++) begin
      @(negedge clk);
      if (poke && (cyc == 5 || cyc == 20)) begin
        start = 1'b1; op_a = $urandom; op_b = $urandom; signed_op = 1'($urandom);
      end else begin
        start = 1'b0;
      end
      if (done) begin
        n_done++;
        if (first_done < 0) begin
          first_done = cyc;
          got = {hi, lo};
        end
      end
      if (cyc <= LAT && !busy) busy_ok = 1'b0;
      if (cyc < LAT && {hi, lo} !== last_res) hold_ok = 1'b0;
    end
    check({tag, " latency"}, 64'(first_done), 64'(LAT));
    check({tag, " done_count"}, 64'(n_done), 64'd1);
    check({tag, " product"}, got, exp);
    check({tag, " busy_during"}, 64'(busy_ok), 64'd1);
    check({tag, " hold_before_done"}, 64'(hold_ok), 64'd1);
    check({tag, " idle_after"}, {63'd0, busy}, 64'd0);
    check({tag, " hold_after"}, {hi, lo}, exp);
    last_res = exp;
  endtask

  typedef struct {
    logic [W-1:0] a;
    logic [W-1:0] b;
    logic         s;
    bit           poke;
  } vec_t;

  function automatic logic [W-1:0] pick_operand();
    case ($urandom_range(0, 5))
      0: return '0;
      1: return 32'h1;
      2: return 32'hFFFF_FFFF;
      3: return 32'h8000_0000;
      4: return 32'h7FFF_FFFF;
      default: return $urandom;
    endcase
  endfunction

  initial begin
    vec_t vecs[$];
    int   seen_done;

    // Reset state.
    repeat (3) @(negedge clk);
    check("reset busy", {63'd0, busy}, 64'd0);
    check("reset done", {63'd0, done}, 64'd0);
    check("reset hilo", {hi, lo}, 64'd0);
    rst_n = 1'b1;

    // Directed corners.
    vecs.push_back('{32'hFFFF_FFFF, 32'hFFFF_FFFF, 1'b0, 1'b0});
    vecs.push_back('{32'hFFFF_FFFD, 32'h0000_0005, 1'b1, 1'b0});
    vecs.push_back('{32'h8000_0000, 32'h8000_0000, 1'b1, 1'b0});
    vecs.push_back('{32'h8000_0000, 32'h0000_0001, 1'b1, 1'b0});
    vecs.push_back('{32'h0000_1234, 32'h0000_5678, 1'b0, 1'b1});
    vecs.push_back('{32'h0000_0000, 32'hFFFF_FFFF, 1'b1, 1'b0});
    foreach (vecs[i]) run_op(vecs[i].a, vecs[i].b, vecs[i].s, vecs[i].poke, $sformatf("dir%0d", i));

    // Random operations, occasionally with ignored start pulses.
    for (int i = 0; i < 16; i++)
      run_op(pick_operand(), pick_operand(), 1'($urandom), ($urandom_range(0, 3) == 0),
             $sformatf("rnd%0d", i));

    // Mid-operation reset during RUN.
    @(negedge clk);
    start = 1'b1; op_a = 32'h0000_0007; op_b = 32'h0000_0009; signed_op = 1'b0;
    for (int cyc = 1; cyc <= 12; cyc++) begin
      @(negedge clk);
      start = 1'b0;
    end
    rst_n = 1'b0;
    @(negedge clk);
    check("midrst busy", {63'd0, busy}, 64'd0);
    check("midrst done", {63'd0, done}, 64'd0);
    check("midrst hilo", {hi, lo}, 64'd0);
    rst_n = 1'b1;
    last_res = '0;
    run_op(32'hFFFF_FFFD, 32'h0000_0005, 1'b1, 1'b0, "post_rst");

`ifdef MULT_SEQ_ABORT_EN
    // Abort in RUN: back to IDLE, no done, previous result kept.
    run_op(32'h2, 32'h3, 1'b0, 1'b0, "pre_abort");
    @(negedge clk);
    start = 1'b1; op_a = 32'h1111_1111; op_b = 32'h2222_2222; signed_op = 1'b0;
    for (int cyc = 1; cyc <= 10; cyc++) begin
      @(negedge clk);
      start = 1'b0;
    end
    abort = 1'b1;
    @(negedge clk);
    abort = 1'b0;
    check("abort busy", {63'd0, busy}, 64'd0);
    seen_done = 0;
    for (int cyc = 0; cyc < LAT + 5; cyc++) begin
      @(negedge clk);
      if (done) seen_done++;
    end
    check("abort no_done", 64'(seen_done), 64'd0);
    check("abort hilo", {hi, lo}, 64'd6);
`else
    seen_done = 0;
`endif

    $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
    $finish;
  end

endmodule : tb_mult_sequencer
